// File: rtl/axis_fifo_buffer.sv
// AXI-Stream FIFO: DEPTH-beat circular RAM plus a registered output stage.
// Optional store-and-forward mode releases a packet only once its tlast beat is held.
module axis_fifo_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   up_tdata,
  input  logic                    up_tlast,
  input  logic                    up_tvalid,
  output logic                    up_tready,
  output logic [DATA_WIDTH-1:0]   dn_tdata,
  output logic                    dn_tlast,
  output logic                    dn_tvalid,
  input  logic                    dn_tready,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {IDLE, STREAM} state_t;

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] stored_pkts;
  logic          rst_q;
  state_t        st, st_nxt;
  beat_t         up_beat, head;
  logic          push, pop, full, ram_empty, avail;
  logic          release_new, may_load, load, ram_wr, ram_rd;

  assign full      = (count == CW'(DEPTH));
  assign up_tready = !rst_q && !full;
  assign push      = up_tvalid && up_tready;
  assign pop       = dn_tvalid && dn_tready;

  assign up_beat   = '{last: up_tlast, data: up_tdata};
  assign ram_empty = (ram_cnt == '0);
  // With an empty RAM the incoming beat bypasses straight into the output stage.
  assign head      = ram_empty ? up_beat : mem[rd_ptr];
  assign avail     = !ram_empty || push;

  // Complete packets behind the output stage; a finished packet sitting in the
  // output register does not count towards releasing the next one.
  assign stored_pkts = pkt_count - CW'(dn_tvalid && dn_tlast);
  // Full with no complete packet means the packet exceeds DEPTH: fall back to cut-through.
  assign release_new = (stored_pkts != '0) || (push && up_tlast) || full;

  assign may_load = (PACKET_MODE == 0) || release_new ||
                    ((st == STREAM) && !(dn_tvalid && dn_tlast));
  assign load     = (!dn_tvalid || pop) && avail && may_load;
  assign ram_rd   = load && !ram_empty;
  assign ram_wr   = push && !(load && ram_empty);

  always_comb begin
    st_nxt = st;
    if (load)
      st_nxt = STREAM;
    else if (pop && dn_tlast)
      st_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      count     <= '0;
      pkt_count <= '0;
      dn_tvalid <= 1'b0;
      dn_tdata  <= '0;
      dn_tlast  <= 1'b0;
      st        <= IDLE;
    end else begin
      if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt   <= ram_cnt + CW'(ram_wr) - CW'(ram_rd);
      count     <= count + CW'(push) - CW'(pop);
      pkt_count <= pkt_count + CW'(push && up_tlast) - CW'(pop && dn_tlast);
      if (load) begin
        dn_tvalid <= 1'b1;
        dn_tdata  <= head.data;
        dn_tlast  <= head.last;
      end else if (pop) begin
        dn_tvalid <= 1'b0;
      end
      st <= st_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= up_beat;
  end

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// Directed bench: cut-through FIFO (DEPTH=16) and store-and-forward FIFO (DEPTH=8).
module tb_axis_fifo_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_up_tdata, a_dn_tdata, b_up_tdata, b_dn_tdata;
  logic        a_up_tlast, a_up_tvalid, a_up_tready, a_dn_tlast, a_dn_tvalid, a_dn_tready;
  logic        b_up_tlast, b_up_tvalid, b_up_tready, b_dn_tlast, b_dn_tvalid, b_dn_tready;
  logic [4:0]  a_count, a_pkt_count;
  logic [3:0]  b_count, b_pkt_count;

  int errors = 0;
  int checks = 0;

  axis_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) u_ct (
    .clk(clk), .rst(rst),
    .up_tdata(a_up_tdata), .up_tlast(a_up_tlast), .up_tvalid(a_up_tvalid), .up_tready(a_up_tready),
    .dn_tdata(a_dn_tdata), .dn_tlast(a_dn_tlast), .dn_tvalid(a_dn_tvalid), .dn_tready(a_dn_tready),
    .count(a_count), .pkt_count(a_pkt_count)
  );

  axis_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(8), .PACKET_MODE(1)) u_sf (
    .clk(clk), .rst(rst),
    .up_tdata(b_up_tdata), .up_tlast(b_up_tlast), .up_tvalid(b_up_tvalid), .up_tready(b_up_tready),
    .dn_tdata(b_dn_tdata), .dn_tlast(b_dn_tlast), .dn_tvalid(b_dn_tvalid), .dn_tready(b_dn_tready),
    .count(b_count), .pkt_count(b_pkt_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    int sent, got, guard, first_pop;

    a_up_tdata = '0; a_up_tlast = 1'b0; a_up_tvalid = 1'b0; a_dn_tready = 1'b0;
    b_up_tdata = '0; b_up_tlast = 1'b0; b_up_tvalid = 1'b0; b_dn_tready = 1'b0;

    // reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_up_tready", 64'(a_up_tready), 64'd0);
    chk("rst_dn_tvalid", 64'(a_dn_tvalid), 64'd0);
    chk("rst_dn_tdata",  64'(a_dn_tdata),  64'd0);
    chk("rst_dn_tlast",  64'(a_dn_tlast),  64'd0);
    chk("rst_count",     64'(a_count),     64'd0);
    chk("rst_pkt_count", 64'(a_pkt_count), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready_a", 64'(a_up_tready), 64'd1);
    chk("post_rst_ready_b", 64'(b_up_tready), 64'd1);

    // fill 16 beats with the sink stalled
    for (int i = 1; i <= 16; i++) begin
      a_up_tvalid = 1'b1; a_up_tdata = 32'(i); a_up_tlast = 1'b0;
      cyc();
    end
    a_up_tvalid = 1'b0;
    chk("fill_count",    64'(a_count),     64'd16);
    chk("fill_ready",    64'(a_up_tready), 64'd0);
    chk("fill_dn_valid", 64'(a_dn_tvalid), 64'd1);
    chk("fill_dn_hold",  64'(a_dn_tdata),  64'd1);

    // drain on consecutive cycles
    a_dn_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_valid", 64'(a_dn_tvalid), 64'd1);
      chk("drain_data",  64'(a_dn_tdata),  64'(i));
      cyc();
    end
    chk("drain_count", 64'(a_count),     64'd0);
    chk("drain_empty", 64'(a_dn_tvalid), 64'd0);
    chk("drain_ready", 64'(a_up_tready), 64'd1);
    a_dn_tready = 1'b0;

    // continuous streaming, 100 beats
    q.delete(); sent = 0; got = 0; guard = 0; first_pop = -1;
    while (got < 100 && guard < 1000) begin
      a_up_tvalid = (sent < 100); a_up_tdata = 32'(1000 + sent); a_up_tlast = 1'b0;
      a_dn_tready = 1'b1;
      if (a_dn_tvalid && a_dn_tready) begin
        if (first_pop < 0) first_pop = guard;
        e = (q.size() > 0) ? q.pop_front() : '1;
        chk("stream_data", 64'({a_dn_tlast, a_dn_tdata}), 64'(e));
        got++;
      end
      if (a_up_tvalid && a_up_tready) begin
        q.push_back({a_up_tlast, a_up_tdata});
        sent++;
      end
      cyc(); guard++;
      chk("stream_count_le1", 64'(a_count <= 5'd1), 64'd1);
    end
    chk("stream_done",    64'(got),       64'd100);
    chk("stream_latency", 64'(first_pop), 64'd1);
    a_up_tvalid = 1'b0; a_dn_tready = 1'b0;
    cyc();
    chk("stream_end_count", 64'(a_count), 64'd0);

    // random valid/ready, tlast every 7th beat
    q.delete(); sent = 0; got = 0; guard = 0;
    while (got < 1000 && guard < 20000) begin
      a_up_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      a_up_tdata  = $urandom;
      a_up_tlast  = ((sent % 7) == 6);
      a_dn_tready = ($urandom_range(0, 1) == 1);
      if (a_dn_tvalid && a_dn_tready) begin
        e = (q.size() > 0) ? q.pop_front() : '1;
        chk("rand_beat", 64'({a_dn_tlast, a_dn_tdata}), 64'(e));
        got++;
      end
      if (a_up_tvalid && a_up_tready) begin
        q.push_back({a_up_tlast, a_up_tdata});
        sent++;
      end
      cyc(); guard++;
      chk("rand_no_overflow", 64'(a_count <= 5'd16), 64'd1);
    end
    a_up_tvalid = 1'b0; a_dn_tready = 1'b0;
    chk("rand_done",      64'(got),         64'd1000);
    chk("rand_count",     64'(a_count),     64'd0);
    chk("rand_pkt_count", 64'(a_pkt_count), 64'd0);

    // store-and-forward: 5-beat packet with gaps
    for (int i = 1; i <= 5; i++) begin
      b_up_tvalid = 1'b1; b_up_tdata = 32'(32'h50 + i); b_up_tlast = (i == 5);
      cyc();
      b_up_tvalid = 1'b0;
      chk("pkt_hold_valid", 64'(b_dn_tvalid), 64'(i == 5));
      if (i < 5) begin
        cyc(); cyc();
        chk("pkt_gap_valid", 64'(b_dn_tvalid), 64'd0);
      end
    end
    chk("pkt_count_one", 64'(b_pkt_count), 64'd1);
    chk("pkt_count_beats", 64'(b_count), 64'd5);
    b_dn_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("pkt_out_valid", 64'(b_dn_tvalid), 64'd1);
      chk("pkt_out_data",  64'(b_dn_tdata),  64'(32'h50 + i));
      chk("pkt_out_last",  64'(b_dn_tlast),  64'(i == 5));
      cyc();
    end
    chk("pkt_end_valid", 64'(b_dn_tvalid),  64'd0);
    chk("pkt_end_pkts",  64'(b_pkt_count), 64'd0);
    b_dn_tready = 1'b0;

    // store-and-forward: 20-beat packet overflows DEPTH=8 and falls back
    q.delete(); sent = 0; got = 0; guard = 0;
    for (int i = 0; i < 9; i++) begin
      b_up_tvalid = 1'b1; b_up_tdata = 32'(256 + sent + 1); b_up_tlast = (sent == 19);
      if (b_up_tready) begin
        q.push_back({b_up_tlast, b_up_tdata});
        sent++;
      end
      cyc();
      chk("ovf_release", 64'(b_dn_tvalid), 64'(i == 8));
    end
    chk("ovf_sent",   64'(sent),        64'd8);
    chk("ovf_count",  64'(b_count),     64'd8);
    chk("ovf_pkts",   64'(b_pkt_count), 64'd0);
    chk("ovf_head",   64'(b_dn_tdata),  64'h101);
    while (got < 20 && guard < 500) begin
      b_up_tvalid = (sent < 20); b_up_tdata = 32'(256 + sent + 1); b_up_tlast = (sent == 19);
      b_dn_tready = 1'b1;
      if (b_dn_tvalid && b_dn_tready) begin
        e = (q.size() > 0) ? q.pop_front() : '1;
        chk("ovf_beat", 64'({b_dn_tlast, b_dn_tdata}), 64'(e));
        got++;
      end
      if (b_up_tvalid && b_up_tready) begin
        q.push_back({b_up_tlast, b_up_tdata});
        sent++;
      end
      cyc(); guard++;
    end
    b_up_tvalid = 1'b0; b_dn_tready = 1'b0;
    chk("ovf_done",      64'(got),         64'd20);
    chk("ovf_end_count", 64'(b_count),     64'd0);
    chk("ovf_end_pkts",  64'(b_pkt_count), 64'd0);
    chk("ovf_end_valid", 64'(b_dn_tvalid), 64'd0);

    // reset mid-stream discards stored beats
    for (int i = 0; i < 5; i++) begin
      a_up_tvalid = 1'b1; a_up_tdata = 32'(32'h60 + i); a_up_tlast = (i == 2);
      cyc();
    end
    a_up_tvalid = 1'b0;
    chk("mid_count", 64'(a_count),     64'd5);
    chk("mid_pkts",  64'(a_pkt_count), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_valid", 64'(a_dn_tvalid), 64'd0);
    chk("mrst_count", 64'(a_count),     64'd0);
    chk("mrst_pkts",  64'(a_pkt_count), 64'd0);
    chk("mrst_ready", 64'(a_up_tready), 64'd0);
    cyc();
    chk("mrst_ready_back", 64'(a_up_tready), 64'd1);
    chk("mrst_no_emit",    64'(a_dn_tvalid), 64'd0);
    a_up_tvalid = 1'b1; a_up_tdata = 32'hAA; a_up_tlast = 1'b1; a_dn_tready = 1'b1;
    cyc();
    a_up_tvalid = 1'b0;
    chk("fresh_valid", 64'(a_dn_tvalid), 64'd1);
    chk("fresh_data",  64'(a_dn_tdata),  64'hAA);
    chk("fresh_last",  64'(a_dn_tlast),  64'd1);
    cyc();
    chk("fresh_alone", 64'(a_dn_tvalid), 64'd0);
    chk("fresh_count", 64'(a_count),     64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
